// File: rtl/sf_pkg.sv
// Shared definitions for the sf flip-flop and its command sequencer:
// op codes, FSM states and the sf next-state function.
package sf_pkg;

  localparam logic [1:0] OP_CLR  = 2'b00;
  localparam logic [1:0] OP_SET  = 2'b01;
  localparam logic [1:0] OP_HOLD = 2'b10;
  localparam logic [1:0] OP_TGL  = 2'b11;

  localparam logic [1:0] HOLD_SF = 2'b10;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_t;

  // Next Q of the sf flop for a given {S,F} pair and current Q.
  function automatic logic sf_next(input logic [1:0] sf, input logic q);
    case (sf)
      OP_CLR:  return 1'b0;
      OP_SET:  return 1'b1;
      OP_HOLD: return q;
      default: return ~q;
    endcase
  endfunction

endpackage

// File: rtl/sf_cmd_fifo.sv
// Synchronous command FIFO; head entry is visible on rdata while not empty.
// Pointers carry one extra bit so full and empty can be told apart.
module sf_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic [W-1:0] mem [DEPTH];
  logic         do_push;
  logic         do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr[AW-1:0]];

  // NOTE: sequential state is always assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // NOTE: storage has no reset; empty/full come from the pointers, so stale data is never read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/sf_cmd_sequencer.sv
// Turns queued CLR/SET/HOLD/TGL ops with repeat counts into one registered
// S/F pair per clock for an sf flop, and checks sf.Q against a shadow model.
module sf_cmd_sequencer
  import sf_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [CNT_W-1:0] in_rep,
  output logic             S,
  output logic             F,
  input  logic             q_in,
  output logic             busy,
  output logic             exp_q,
  output logic             exp_known,
  output logic             mismatch
);

  localparam int W = 2 + CNT_W;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       sf_r;
  logic [W-1:0]     head;
  logic [1:0]       head_op;
  logic [CNT_W-1:0] head_rep;
  logic             full;
  logic             empty;
  logic             push;
  logic             load;

  assign in_ready = !full;
  assign push     = in_valid && in_ready;
  assign head_op  = head[CNT_W +: 2];
  assign head_rep = head[CNT_W-1:0];
  assign S        = sf_r[1];
  assign F        = sf_r[0];
  assign busy     = (state == ISSUE) || !empty;

  // A new op is taken from IDLE, or back-to-back when the current one issues its last cycle.
  assign load = !empty && ((state == IDLE) || (cnt == '0));

  sf_cmd_fifo #(
    .DEPTH(DEPTH),
    .W    (W)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .wdata({in_op, in_rep}),
    .pop  (load),
    .rdata(head),
    .full (full),
    .empty(empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      sf_r      <= HOLD_SF;
      exp_q     <= 1'b0;
      exp_known <= 1'b0;
      mismatch  <= 1'b0;
    end else begin
      // Shadow follows the S/F pair sf sees on this same edge; the check uses pre-edge values.
      exp_q <= sf_next(sf_r, exp_q);
      if (sf_r == OP_CLR || sf_r == OP_SET) exp_known <= 1'b1;
      if (exp_known && (q_in != exp_q))     mismatch  <= 1'b1;

      if (load) begin
        sf_r  <= head_op;
        cnt   <= head_rep;
        state <= ISSUE;
      end else if (state == ISSUE && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end else begin
        sf_r  <= HOLD_SF;
        state <= IDLE;
      end
    end
  end

endmodule
